factory_pattern_checker: RTL and testbench



---
 rtl/factory_test_pkg.sv | 24 ++
 rtl/sat_counter.sv | 39 +++
 rtl/factory_pattern_checker.sv | 172 +++++++++++++++++
 tb/tb_factory_pattern_checker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/factory_test_pkg.sv
// Shared types and helpers for the factory-test counter-stream checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package factory_test_pkg;

   typedef enum logic [1:0] {
      ACQ    = 2'd0,
      LOCKED = 2'd1,
      FAIL   = 2'd2
   } state_t;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_LOCK_COUNT = 4;
   localparam int DEF_ERR_W      = 16;
   localparam int DEF_ERR_LIMIT  = 255;

   // Next value of the counter stream after 'data'. The caller truncates the
   // result to its bus width, which gives the modulo-2**WIDTH wrap for free.
   function automatic logic [31:0] next_val(input logic [31:0] data,
                                            input logic        mode_down);
      return mode_down ? (data - 32'd1) : (data + 32'd1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count updates 1 cycle after inc/clr.
// Backpressure: none; inc is ignored once saturated.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc, cnt[W-1:0].
module sat_counter
#(
   parameter int W = 16
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/factory_pattern_checker.sv
// Checks an incoming 8-bit up/down counter stream: acquires lock, counts mismatches, flags fail.
// Latency: all outputs registered, 1 cycle after the qualifying sample edge.
// Backpressure: none; sample_en qualifies data_in, idle cycles change nothing.
// Ports: clk, rst (sync, active-high), sample_en, data_in, mode_down, clear (soft reset);
//        outputs locked, fail (sticky), err_cnt (saturating), match_cnt (acquisition run length).
// Macro FACTORY_PATTERN_CHECK_LOG_EN adds first_exp/first_got/first_valid, capturing the
// first mismatch seen while locked.
module factory_pattern_checker
   import factory_test_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int ERR_W      = DEF_ERR_W,
   parameter int ERR_LIMIT  = DEF_ERR_LIMIT
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             mode_down,
   input  logic             clear,
   output logic             locked,
   output logic             fail,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       match_cnt
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
   ,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got,
   output logic             first_valid
`endif
);

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] expected_q,  expected_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic             first_q,     first_d;
   logic             locked_q,    locked_d;
   logic             fail_q,      fail_d;
   logic             mode_q;

   logic             err_inc;
   logic             mode_chg;
   logic             mismatch;
   logic             limit_hit;
   logic [3:0]       match_inc;
   logic [WIDTH-1:0] nxt;

`ifdef FACTORY_PATTERN_CHECK_LOG_EN
   logic [WIDTH-1:0] first_exp_q, first_exp_d;
   logic [WIDTH-1:0] first_got_q, first_got_d;
   logic             first_valid_q, first_valid_d;
`endif

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (err_inc),
      .cnt (err_cnt)
   );

   assign nxt       = WIDTH'(next_val(32'(data_in), mode_down));
   assign mode_chg  = (mode_down != mode_q);
   assign mismatch  = (data_in != expected_q);
   assign limit_hit = (err_cnt >= ERR_W'(ERR_LIMIT));
   assign match_inc = mismatch ? 4'd0 : (match_cnt_q + 4'd1);

   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      match_cnt_d = match_cnt_q;
      first_d     = first_q;
      fail_d      = fail_q;
      err_inc     = 1'b0;
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
      first_exp_d   = first_exp_q;
      first_got_d   = first_got_q;
      first_valid_d = first_valid_q;
`endif
      if (clear) begin
         state_d     = ACQ;
         expected_d  = '0;
         match_cnt_d = '0;
         first_d     = 1'b1;
         fail_d      = 1'b0;
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
         first_exp_d   = '0;
         first_got_d   = '0;
         first_valid_d = 1'b0;
`endif
      end else if (state_q != FAIL) begin
         // Limit check is on the registered count, so fail trails the
         // count by one cycle; samples in that cycle are dropped so the
         // count stays frozen at the limit.
         if (limit_hit) begin
            state_d = FAIL;
            fail_d  = 1'b1;
         end else if (mode_chg) begin
            // Direction flipped: restart acquisition, drop this sample.
            state_d     = ACQ;
            first_d     = 1'b1;
            match_cnt_d = '0;
         end else if (sample_en) begin
            expected_d = nxt;  // always reseed from the observed data
            if (state_q == ACQ) begin
               if (first_q) begin
                  first_d     = 1'b0;
                  match_cnt_d = '0;
               end else begin
                  match_cnt_d = match_inc;
                  if (!mismatch && (match_inc == 4'(LOCK_COUNT))) begin
                     state_d = LOCKED;
                  end
               end
            end else if (mismatch) begin
               err_inc = 1'b1;
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
               if (!first_valid_q) begin
                  first_exp_d   = expected_q;
                  first_got_d   = data_in;
                  first_valid_d = 1'b1;
               end
`endif
            end
         end
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACQ;
         expected_q  <= '0;
         match_cnt_q <= '0;
         first_q     <= 1'b1;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
         // Track the live direction so leaving reset is not seen as a flip.
         mode_q      <= mode_down;
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
         first_exp_q   <= '0;
         first_got_q   <= '0;
         first_valid_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         match_cnt_q <= match_cnt_d;
         first_q     <= first_d;
         locked_q    <= locked_d;
         fail_q      <= fail_d;
         mode_q      <= mode_down;
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
         first_exp_q   <= first_exp_d;
         first_got_q   <= first_got_d;
         first_valid_q <= first_valid_d;
`endif
      end
   end

   assign locked    = locked_q;
   assign fail      = fail_q;
   assign match_cnt = match_cnt_q;
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
   assign first_exp   = first_exp_q;
   assign first_got   = first_got_q;
   assign first_valid = first_valid_q;
`endif

endmodule

// File: tb/tb_factory_pattern_checker.sv
// Scoreboard bench for factory_pattern_checker (LOCK_COUNT=4, ERR_LIMIT=3).
// Latency: each driven cycle's expected outputs are checked #1 after the following posedge.
// Backpressure: n/a.
module tb_factory_pattern_checker;

   logic        clk;
   logic        rst;
   logic        sample_en;
   logic [7:0]  data_in;
   logic        mode_down;
   logic        clear;
   logic        locked;
   logic        fail;
   logic [15:0] err_cnt;
   logic [3:0]  match_cnt;
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
   logic [7:0]  first_exp;
   logic [7:0]  first_got;
   logic        first_valid;
`endif

   factory_pattern_checker #(
      .WIDTH(8), .LOCK_COUNT(4), .ERR_W(16), .ERR_LIMIT(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .data_in   (data_in),
      .mode_down (mode_down),
      .clear     (clear),
      .locked    (locked),
      .fail      (fail),
      .err_cnt   (err_cnt),
      .match_cnt (match_cnt)
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
      ,
      .first_exp   (first_exp),
      .first_got   (first_got),
      .first_valid (first_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          chk;
      logic        locked;
      logic        fail;
      logic [15:0] err;
      int          match;   // -1: not checked
      bit          chk_log;
      logic        lv;
      logic [7:0]  le;
      logic [7:0]  lg;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic cur_md  = 1'b0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: pops one expectation per cycle and compares against live outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.chk) begin
               cmp({e.name, " locked"}, 32'(locked), 32'(e.locked));
               cmp({e.name, " fail"},   32'(fail),   32'(e.fail));
               cmp({e.name, " err_cnt"}, 32'(err_cnt), 32'(e.err));
               if (e.match >= 0)
                  cmp({e.name, " match_cnt"}, 32'(match_cnt), 32'(e.match));
`ifdef FACTORY_PATTERN_CHECK_LOG_EN
               if (e.chk_log) begin
                  cmp({e.name, " first_valid"}, 32'(first_valid), 32'(e.lv));
                  cmp({e.name, " first_exp"},   32'(first_exp),   32'(e.le));
                  cmp({e.name, " first_got"},   32'(first_got),   32'(e.lg));
               end
`endif
            end
         end
      end
   end

   task automatic step(input bit r, input bit c, input bit en, input logic [7:0] d,
                       input bit chk, input logic el, input logic ef,
                       input logic [15:0] ee, input int em, input string nm,
                       input bit cl = 1'b0, input logic lv = 1'b0,
                       input logic [7:0] le = 8'h00, input logic [7:0] lg = 8'h00);
      exp_t e;
      @(negedge clk);
      rst       = r;
      clear     = c;
      sample_en = en;
      data_in   = d;
      mode_down = cur_md;
      e.chk = chk; e.locked = el; e.fail = ef; e.err = ee; e.match = em;
      e.chk_log = cl; e.lv = lv; e.le = le; e.lg = lg; e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic smp(input logic [7:0] d, input bit chk, input logic el, input logic ef,
                      input logic [15:0] ee, input int em, input string nm);
      step(1'b0, 1'b0, 1'b1, d, chk, el, ef, ee, em, nm);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; sample_en = 1'b0; data_in = 8'h00; mode_down = 1'b0;

      step(1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 0, 16'd0, 0, "reset");

      // Up-count acquisition, with a 3-cycle sample gap mid-run.
      smp(8'h10, 1, 0, 0, 16'd0, 0, "t1 s10");
      smp(8'h11, 1, 0, 0, 16'd0, 1, "t1 s11");
      smp(8'h12, 1, 0, 0, 16'd0, 2, "t1 s12");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b0, 8'hEE, 1, 0, 0, 16'd0, 2, "t6 gap");
      smp(8'h13, 1, 0, 0, 16'd0, 3, "t1 s13");
      smp(8'h14, 1, 1, 0, 16'd0, -1, "t1 lock");

      // Run the locked stream up to the wrap point.
      for (int v = 8'h15; v <= 8'hFD; v++) smp(v[7:0], 0, 0, 0, 16'd0, -1, "");
      smp(8'hFE, 1, 1, 0, 16'd0, -1, "t2 upFE");
      smp(8'hFF, 1, 1, 0, 16'd0, -1, "t2 upFF");
      smp(8'h00, 1, 1, 0, 16'd0, -1, "t2 up00");
      smp(8'h01, 1, 1, 0, 16'd0, -1, "t2 up01");

      // Single glitched sample costs two errors.
      for (int v = 8'h02; v <= 8'h1F; v++) smp(v[7:0], 0, 0, 0, 16'd0, -1, "");
      smp(8'h20, 1, 1, 0, 16'd0, -1, "t3 s20");
      smp(8'h21, 1, 1, 0, 16'd0, -1, "t3 s21");
      smp(8'h55, 1, 1, 0, 16'd1, -1, "t3 glitch");
      smp(8'h23, 1, 1, 0, 16'd2, -1, "t3 return");
      smp(8'h24, 1, 1, 0, 16'd2, -1, "t3 s24");

      // Flip to down-count: sample in the flip cycle is ignored, relock, wrap down.
      cur_md = 1'b1;
      smp(8'h25, 1, 0, 0, 16'd2, 0, "t5 mode chg");
      smp(8'h05, 1, 0, 0, 16'd2, 0, "t5 s05");
      smp(8'h04, 1, 0, 0, 16'd2, 1, "t5 s04");
      smp(8'h03, 1, 0, 0, 16'd2, 2, "t5 s03");
      smp(8'h02, 1, 0, 0, 16'd2, 3, "t5 s02");
      smp(8'h01, 1, 1, 0, 16'd2, -1, "t5 relock");
      smp(8'h00, 1, 1, 0, 16'd2, -1, "t2 dn00");
      smp(8'hFF, 1, 1, 0, 16'd2, -1, "t2 dnFF");
      smp(8'hFE, 1, 1, 0, 16'd2, -1, "t2 dnFE");

      // Mismatch and mode flip together: no error counted.
      cur_md = 1'b0;
      smp(8'h77, 1, 0, 0, 16'd2, 0, "simul flip");
      smp(8'h30, 1, 0, 0, 16'd2, 0, "relock s30");
      smp(8'h31, 1, 0, 0, 16'd2, 1, "relock s31");
      smp(8'h32, 1, 0, 0, 16'd2, 2, "relock s32");
      smp(8'h33, 1, 0, 0, 16'd2, 3, "relock s33");
      smp(8'h34, 1, 1, 0, 16'd2, -1, "relock s34");

      // Garbage until the limit of 3; fail follows one cycle later, count freezes.
      smp(8'h80, 1, 1, 0, 16'd3, -1, "t4 err hit");
      smp(8'h90, 1, 0, 1, 16'd3, -1, "t4 fail");
      smp(8'hA0, 1, 0, 1, 16'd3, -1, "t4 frozenA0");
      step(1'b0, 1'b0, 1'b1, 8'hB0, 1, 0, 1, 16'd3, -1, "t4 frozenB0",
           1'b1, 1'b1, 8'h22, 8'h55);

      // Clear wins over a simultaneous sample.
      step(1'b0, 1'b1, 1'b1, 8'h35, 1, 0, 0, 16'd0, 0, "t6 clear",
           1'b1, 1'b0, 8'h00, 8'h00);
      smp(8'h40, 1, 0, 0, 16'd0, 0, "post clr s40");
      smp(8'h41, 1, 0, 0, 16'd0, 1, "post clr s41");

      step(1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 16'd0, -1, "");
      repeat (3) @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
